// File: rtl/channel_select_pkg.sv
// Shared constants and helpers for the registered channel selector.
// Mode encodings and lane slicing of the flattened input bus.
package channel_select_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // LSB position of a lane within a flattened {lane N-1, ..., lane 0} bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/channel_select_reg_rr_pick.sv
// Rotating-priority request picker: first requester at or after base, wrapping.
// Purely combinational; base is expected to be below CHANNELS.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    base,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [2*CHANNELS-1:0] req_dbl;
    logic [2*CHANNELS-1:0] req_rot;
    logic [SEL_W:0]        offs_sum;

    // Doubling the request vector turns the wrap-around search into a plain shift.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> base;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        offs_sum    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_valid = 1'b1;
                offs_sum    = {1'b0, base} + (SEL_W+1)'(i);
                if (offs_sum >= (SEL_W+1)'(CHANNELS)) begin
                    offs_sum = offs_sum - (SEL_W+1)'(CHANNELS);
                end
                grant_idx = offs_sum[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/channel_select_reg.sv
// Registered N:1 lane selector, fixed-address or round-robin, with a
// one-deep valid/ready output register that reloads while draining.
module channel_select_reg
    import channel_select_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          address,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] lane_data [CHANNELS];

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             fixed_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_reg,    out_data_next;
    logic [SEL_W-1:0] out_channel_reg, out_channel_next;
    logic             out_valid_reg,   out_valid_next;
    logic [SEL_W-1:0] ptr_reg,         ptr_next;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign lane_data[gi] = in_data[lane_lsb(gi, WIDTH) +: WIDTH];
            assign in_ready[gi]  = xfer && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .req         (in_valid),
        .base        (ptr_reg),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Matching against real lane indices rejects out-of-range addresses for free.
    always_comb begin
        fixed_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if ((address == SEL_W'(k)) && in_valid[k]) begin
                fixed_valid = 1'b1;
            end
        end
    end

    assign grant_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
    assign grant_idx   = (mode == MODE_RR) ? rr_idx   : address;
    assign load_en     = !out_valid_reg || out_ready;
    assign xfer        = grant_valid && load_en && !reset;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data = lane_data[k];
            end
        end
    end

    always_comb begin
        out_data_next    = out_data_reg;
        out_channel_next = out_channel_reg;
        out_valid_next   = out_valid_reg;
        ptr_next         = ptr_reg;
        if (xfer) begin
            out_data_next    = sel_data;
            out_channel_next = grant_idx;
            out_valid_next   = 1'b1;
            ptr_next         = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg    <= '0;
            out_channel_reg <= '0;
            out_valid_reg   <= 1'b0;
            ptr_reg         <= '0;
        end else begin
            out_data_reg    <= out_data_next;
            out_channel_reg <= out_channel_next;
            out_valid_reg   <= out_valid_next;
            ptr_reg         <= ptr_next;
        end
    end

    assign out_data    = out_data_reg;
    assign out_channel = out_channel_reg;
    assign out_valid   = out_valid_reg;

endmodule
